load_store_unit: RTL and testbench

Data-memory access stage of the RISC-V core, directly downstream of the ALU. It takes the ALU result as the effective address and drives a word-wide data-memory bus using a valid/ready handshake. It also generates byte enables and replicated store data, and returns sign- or zero-extended load data. While an access is in flight it holds the core with `o_stall`, and it flags misaligned, illegal-width and timed-out accesses.

---
 rtl/pa_riscv.sv | 31 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pa_riscv.sv
// rtl/pa_riscv.sv - shared RISC-V core types for the load/store stage
package pa_riscv;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store replication, access checks and load extension
module lsu_align
  import pa_riscv::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output err_code_e   err,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic illegal;
  logic misalign;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // funct3[1:0] encodes width for both loads and stores; bit 2 only means unsigned for loads
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    if (we)
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else
      illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
    misalign = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
               ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
    if (illegal)
      err = ERR_ILLEGAL;
    else if (misalign)
      err = ERR_MISALIGN;
    else
      err = ERR_NONE;
  end

  always_comb begin
    byte_lane = rdata[{ld_off, 3'b000} +: 8];
    half_lane = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      LB:      load_data = {{24{byte_lane[7]}}, byte_lane};
      LH:      load_data = {{16{half_lane[15]}}, half_lane};
      LW:      load_data = rdata;
      LBU:     load_data = {24'd0, byte_lane};
      LHU:     load_data = {16'd0, half_lane};
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage with valid/ready bus and timeout
module load_store_unit
  import pa_riscv::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_loadData,
  output logic        o_error,
  output logic [1:0]  o_errCode,
  output logic        o_memValid,
  output logic        o_memWe,
  output logic [31:0] o_memAddr,
  output logic [3:0]  o_memBe,
  output logic [31:0] o_memWdata,
  input  logic        i_memReady,
  input  logic [31:0] i_memRdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  lsu_state_e    state;
  logic [CW-1:0] cnt;
  logic [2:0]    ld_funct3;
  logic [1:0]    ld_off;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  err_code_e     req_err;
  logic [31:0]   load_ext;

  lsu_align u_align (
    .funct3     (i_funct3),
    .we         (i_we),
    .addr_lo    (i_addr[1:0]),
    .store_data (i_storeData),
    .be         (req_be),
    .wdata      (req_wdata),
    .err        (req_err),
    .ld_funct3  (ld_funct3),
    .ld_off     (ld_off),
    .rdata      (i_memRdata),
    .load_data  (load_ext)
  );

  assign o_stall = ((state == IDLE) & i_req) | (state == ACCESS);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_funct3  <= 3'b000;
      ld_off     <= 2'b00;
      o_done     <= 1'b0;
      o_loadData <= 32'd0;
      o_error    <= 1'b0;
      o_errCode  <= ERR_NONE;
      o_memValid <= 1'b0;
      o_memWe    <= 1'b0;
      o_memAddr  <= 32'd0;
      o_memBe    <= 4'b0000;
      o_memWdata <= 32'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            if (req_err != ERR_NONE) begin
              // rejected before any bus traffic
              state      <= RESP;
              o_done     <= 1'b1;
              o_error    <= 1'b1;
              o_errCode  <= req_err;
              o_loadData <= 32'd0;
            end else begin
              state      <= ACCESS;
              cnt        <= '0;
              o_memValid <= 1'b1;
              o_memWe    <= i_we;
              o_memAddr  <= {i_addr[31:2], 2'b00};
              o_memBe    <= req_be;
              o_memWdata <= req_wdata;
              ld_funct3  <= i_funct3;
              ld_off     <= i_addr[1:0];
            end
          end
        end
        ACCESS: begin
          if (i_memReady) begin
            state      <= RESP;
            o_memValid <= 1'b0;
            o_done     <= 1'b1;
            o_error    <= 1'b0;
            o_errCode  <= ERR_NONE;
            o_loadData <= o_memWe ? 32'd0 : load_ext;
          end else if (cnt == CNT_LAST) begin
            state      <= RESP;
            o_memValid <= 1'b0;
            o_done     <= 1'b1;
            o_error    <= 1'b1;
            o_errCode  <= ERR_TIMEOUT;
            o_loadData <= 32'd0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          o_error    <= 1'b0;
          o_errCode  <= ERR_NONE;
          o_loadData <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        arst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        error;
  logic [1:0]  err_code;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] load;
    int          cycle;
    int          nvalid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_arst_n    (arst_n),
    .i_req       (req),
    .i_we        (we),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_storeData (store_data),
    .o_stall     (stall),
    .o_done      (done),
    .o_loadData  (load_data),
    .o_error     (error),
    .o_errCode   (err_code),
    .o_memValid  (mem_valid),
    .o_memWe     (mem_we),
    .o_memAddr   (mem_addr),
    .o_memBe     (mem_be),
    .o_memWdata  (mem_wdata),
    .i_memReady  (mem_ready),
    .i_memRdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // wait_cy: ready is raised in the (wait_cy+1)-th valid cycle; -1 never raises it
  task automatic run_op(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                        input int wait_cy, input logic exp_err, input logic [1:0] exp_code,
                        input logic [31:0] exp_load, input int exp_valid,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    int   nvalid;
    logic done_seen;
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd; mem_ready = 1'b0;
    sb.push_back('{exp_err, exp_code, exp_load, exp_valid + 1, exp_valid});
    #1;
    check({name, ".stall0"}, 32'(stall), 32'd1);
    nvalid = 0;
    done_seen = 1'b0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          check({name, ".mem_addr"}, mem_addr, exp_addr);
          check({name, ".mem_be"}, 32'(mem_be), 32'(exp_be));
          check({name, ".mem_wdata"}, mem_wdata, exp_wdata);
          check({name, ".mem_we"}, 32'(mem_we), 32'(w));
          check({name, ".stall_acc"}, 32'(stall), 32'd1);
        end
        mem_ready = ((nvalid - 1) == wait_cy);
      end else begin
        mem_ready = 1'b0;
      end
      if (done) begin
        done_seen = 1'b1;
        check({name, ".sb_nonempty"}, 32'(sb.size()), 32'(sb.size() > 0 ? sb.size() : 1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({name, ".error"}, 32'(error), 32'(e.err));
          check({name, ".err_code"}, 32'(err_code), 32'(e.code));
          check({name, ".load_data"}, load_data, e.load);
          check({name, ".done_cycle"}, 32'(c), 32'(e.cycle));
          check({name, ".valid_cycles"}, 32'(nvalid), 32'(e.nvalid));
          check({name, ".stall_done"}, 32'(stall), 32'd0);
        end
      end
    end
    check({name, ".done_seen"}, 32'(done_seen), 32'd1);
    req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    check({name, ".idle_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    arst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'd0;
    store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst.mem_valid", 32'(mem_valid), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.load_data", load_data, 32'd0);
    check("rst.err_code", 32'(err_code), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    arst_n = 1'b1;

    //      name       we    f3      addr          sdata         rdata         wait err  code   load          nv addr          be       wdata
    run_op("sw",       1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 0, 1'b0, 2'b00, 32'h0000_0000, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    run_op("sb",       1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h1111_1111, 0, 1'b0, 2'b00, 32'h0000_0000, 1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    run_op("sh",       1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,         1, 1'b0, 2'b00, 32'h0000_0000, 2, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
    run_op("lb",       1'b0, 3'b000, 32'h0000_0102, 32'h0,         32'h12F0_3456, 0, 1'b0, 2'b00, 32'hFFFF_FFF0, 1, 32'h0000_0100, 4'b0100, 32'h0);
    run_op("lbu",      1'b0, 3'b100, 32'h0000_0102, 32'h0,         32'h12F0_3456, 1, 1'b0, 2'b00, 32'h0000_00F0, 2, 32'h0000_0100, 4'b0100, 32'h0);
    run_op("lh",       1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h12F0_3456, 0, 1'b0, 2'b00, 32'h0000_12F0, 1, 32'h0000_0100, 4'b1100, 32'h0);
    run_op("lhu_lo",   1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h8001_F234, 0, 1'b0, 2'b00, 32'h0000_F234, 1, 32'h0000_0100, 4'b0011, 32'h0);
    run_op("lh_lo",    1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h8001_F234, 0, 1'b0, 2'b00, 32'hFFFF_F234, 1, 32'h0000_0100, 4'b0011, 32'h0);
    run_op("lw",       1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 2'b00, 32'hCAFE_F00D, 3, 32'h0000_0104, 4'b1111, 32'h0);
    run_op("lw_mis",   1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 2'b01, 32'h0000_0000, 0, 32'h0,         4'b0000, 32'h0);
    run_op("sh_mis",   1'b1, 3'b001, 32'h0000_0101, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b1, 2'b01, 32'h0000_0000, 0, 32'h0,         4'b0000, 32'h0);
    run_op("ld_ill",   1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 2'b11, 32'h0000_0000, 0, 32'h0,         4'b0000, 32'h0);
    run_op("st_ill",   1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 2'b11, 32'h0000_0000, 0, 32'h0,         4'b0000, 32'h0);
    run_op("timeout",  1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'hFFFF_FFFF, -1, 1'b1, 2'b10, 32'h0000_0000, TIMEOUT, 32'h0000_0300, 4'b1111, 32'h0);
    run_op("late_rdy", 1'b0, 3'b010, 32'h0000_0304, 32'h0,         32'h55AA_55AA, TIMEOUT - 1, 1'b0, 2'b00, 32'h55AA_55AA, TIMEOUT, 32'h0000_0304, 4'b1111, 32'h0);

    // reset while a store is on the bus
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0000_0200; store_data = 32'h1357_9BDF; mem_ready = 1'b0;
    @(negedge clk);
    check("arst.valid_before", 32'(mem_valid), 32'd1);
    #2;
    arst_n = 1'b0;
    req = 1'b0;
    #1;
    check("arst.valid_async", 32'(mem_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst.no_done", 32'(done), 32'd0);
    end
    arst_n = 1'b1;
    run_op("sw_after", 1'b1, 3'b010, 32'h0000_0200, 32'h0BAD_F00D, 32'h0,      0, 1'b0, 2'b00, 32'h0000_0000, 1, 32'h0000_0200, 4'b1111, 32'h0BAD_F00D);

    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
